instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue.sv | 114 +++++++++++
 tb/tb_instr_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Purpose: FIFO of fetched instructions between fetch and decode, with branch-flush and sticky overflow.
// Latency: 1 cycle push-to-d_valid; head fields are first-word-fall-through from the entry at rd_ptr.
// Backpressure: fetch_hold asserts at DEPTH-1 entries; pushes into a full queue are dropped and flagged.
//
// Ports:
//   clk, reset                      - single clock, synchronous active-high reset
//   f_valid/f_instruction/f_cur_pc/f_incremented_pc - fetch-side push
//   fetch_hold                      - asks fetch to stop presenting instructions
//   pc_src/branch_target            - redirect to fetch, straight from execute
//   ex_branch_taken/ex_branch_target - execute-side taken branch (flushes the queue)
//   d_valid/d_ready/d_*             - decode-side head entry and handshake
//   count, overflow_err             - occupancy and sticky dropped-push flag

// Widths normally come from definitions.vh; these defaults keep the file standalone.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_queue #(
    parameter int DEPTH = 4  // power of two, 2..16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    f_valid,
    input  logic [`INSTR_LEN-1:0]   f_instruction,
    input  logic [`WORD-1:0]        f_cur_pc,
    input  logic [`WORD-1:0]        f_incremented_pc,
    output logic                    fetch_hold,
    output logic                    pc_src,
    output logic [`WORD-1:0]        branch_target,
    input  logic                    ex_branch_taken,
    input  logic [`WORD-1:0]        ex_branch_target,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [`INSTR_LEN-1:0]   d_instruction,
    output logic [`WORD-1:0]        d_pc,
    output logic [`WORD-1:0]        d_incremented_pc,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [`INSTR_LEN-1:0] instr;
        logic [`WORD-1:0]      pc;
        logic [`WORD-1:0]      inc_pc;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            overflow_q;

    logic            full;
    logic            push;
    logic            pop;
    entry_t          head;

    assign full = (count_q == CW'(DEPTH));
    // A taken branch kills both sides: the incoming fetch is on the wrong path
    // and decode must not consume anything that is about to be discarded.
    assign push = f_valid && !full && !ex_branch_taken;
    assign pop  = d_valid && d_ready && !ex_branch_taken;

    assign head             = mem[rd_ptr];
    assign d_valid          = (count_q != '0);
    assign d_instruction    = head.instr;
    assign d_pc             = head.pc;
    assign d_incremented_pc = head.inc_pc;

    // Hold one entry early: the instruction already in flight from fetch
    // still lands in the last free slot.
    assign fetch_hold = (count_q >= CW'(DEPTH - 1));

    assign pc_src        = ex_branch_taken;
    assign branch_target = ex_branch_target;

    assign count        = count_q;
    assign overflow_err = overflow_q;

    // Control state. Reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (ex_branch_taken) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
            if (f_valid && full) overflow_q <= 1'b1;
        end
    end

    // Entry storage carries no reset; contents are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{instr: f_instruction, pc: f_cur_pc, inc_pc: f_incremented_pc};
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Purpose: scoreboard bench for instr_queue (DEPTH=4) driven by directed vectors.
// Latency: driver model predicts occupancy one edge ahead; monitor checks every decode handshake.
// Backpressure: d_ready is driven per vector to exercise stall, drain and overflow.

`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_instr_queue;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   f_valid;
    logic [`INSTR_LEN-1:0]  f_instruction;
    logic [`WORD-1:0]       f_cur_pc;
    logic [`WORD-1:0]       f_incremented_pc;
    logic                   fetch_hold;
    logic                   pc_src;
    logic [`WORD-1:0]       branch_target;
    logic                   ex_branch_taken;
    logic [`WORD-1:0]       ex_branch_target;
    logic                   d_valid;
    logic                   d_ready;
    logic [`INSTR_LEN-1:0]  d_instruction;
    logic [`WORD-1:0]       d_pc;
    logic [`WORD-1:0]       d_incremented_pc;
    logic [2:0]             count;
    logic                   overflow_err;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .f_valid          (f_valid),
        .f_instruction    (f_instruction),
        .f_cur_pc         (f_cur_pc),
        .f_incremented_pc (f_incremented_pc),
        .fetch_hold       (fetch_hold),
        .pc_src           (pc_src),
        .branch_target    (branch_target),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .d_valid          (d_valid),
        .d_ready          (d_ready),
        .d_instruction    (d_instruction),
        .d_pc             (d_pc),
        .d_incremented_pc (d_incremented_pc),
        .count            (count),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         exp_cnt = 0;
    bit         exp_ovf = 1'b0;
    logic [63:0] sb_q[$];

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted decode handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset === 1'b0 && ex_branch_taken === 1'b0 && d_valid === 1'b1 && d_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual_pc=%h expected=none at %0t", d_pc, $time);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                chk("pop_pc", d_pc, e);
                chk("pop_instr", {32'h0, d_instruction}, {32'h0, instr_of(e)});
                chk("pop_inc_pc", d_incremented_pc, e + 64'd4);
            end
        end
    end

    // One cycle of stimulus: drive inputs, check combinational outputs and head,
    // advance the model across the edge, then check registered state.
    task automatic cyc(input bit rst, input bit fv, input logic [63:0] pc,
                       input bit dr, input bit br, input logic [63:0] tgt);
        bit do_push;
        bit do_pop;
        reset            = rst;
        f_valid          = fv;
        f_cur_pc         = pc;
        f_instruction    = instr_of(pc);
        f_incremented_pc = pc + 64'd4;
        d_ready          = dr;
        ex_branch_taken  = br;
        ex_branch_target = tgt;
        #1;
        chk("pc_src", {63'h0, pc_src}, {63'h0, br});
        chk("branch_target", branch_target, tgt);
        if (!rst) begin
            chk("fetch_hold", {63'h0, fetch_hold}, {63'h0, (exp_cnt >= DEPTH - 1)});
            chk("d_valid_pre", {63'h0, d_valid}, {63'h0, (exp_cnt != 0)});
            if (exp_cnt != 0) begin
                chk("head_pc", d_pc, sb_q[0]);
                chk("head_instr", {32'h0, d_instruction}, {32'h0, instr_of(sb_q[0])});
                chk("head_inc_pc", d_incremented_pc, sb_q[0] + 64'd4);
            end
        end
        do_push = fv && (exp_cnt < DEPTH) && !br && !rst;
        do_pop  = (exp_cnt != 0) && dr && !br && !rst;
        if (do_push) sb_q.push_back(pc);
        @(posedge clk);
        #2;
        if (rst) begin
            exp_cnt = 0;
            exp_ovf = 1'b0;
            sb_q.delete();
        end else if (br) begin
            exp_cnt = 0;
            sb_q.delete();
        end else begin
            if (fv && exp_cnt == DEPTH) exp_ovf = 1'b1;
            exp_cnt = exp_cnt + int'(do_push) - int'(do_pop);
        end
        chk("count", {61'h0, count}, 64'(exp_cnt));
        chk("overflow_err", {63'h0, overflow_err}, {63'h0, exp_ovf});
        chk("d_valid_post", {63'h0, d_valid}, {63'h0, (exp_cnt != 0)});
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached at %0t", $time);
        $fatal(1);
    end

    initial begin
        // Reset
        cyc(1, 0, 64'h0, 0, 0, 64'h0);
        cyc(1, 0, 64'h0, 0, 0, 64'h0);
        cyc(0, 0, 64'h0, 0, 0, 64'h0);

        // Fill with decode stalled, then drain in order
        cyc(0, 1, 64'h0, 0, 0, 64'h0);
        cyc(0, 1, 64'h4, 0, 0, 64'h0);
        cyc(0, 1, 64'h8, 0, 0, 64'h0);
        cyc(0, 1, 64'hC, 0, 0, 64'h0);
        cyc(0, 0, 64'h0, 0, 0, 64'h0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 64'h0, 1, 0, 64'h0);
        cyc(0, 0, 64'h0, 1, 0, 64'h0);

        // Two entries, then ten cycles of simultaneous push/pop across the wrap
        cyc(0, 1, 64'h10, 0, 0, 64'h0);
        cyc(0, 1, 64'h14, 0, 0, 64'h0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 64'h18 + 64'(4 * i), 1, 0, 64'h0);

        // Stall with pushes continuing into overflow; head must not move
        cyc(0, 1, 64'h80, 0, 0, 64'h0);
        cyc(0, 1, 64'h84, 0, 0, 64'h0);
        cyc(0, 1, 64'h88, 0, 0, 64'h0);
        cyc(0, 1, 64'h8C, 0, 0, 64'h0);
        cyc(0, 1, 64'h90, 0, 0, 64'h0);

        // Drop to three entries, then flush with a same-cycle push and pop request
        cyc(0, 0, 64'h0, 1, 0, 64'h0);
        cyc(0, 1, 64'h94, 1, 1, 64'h100);
        cyc(0, 0, 64'h0, 1, 0, 64'h0);

        // Mid-run reset clears entries and the sticky error
        cyc(0, 1, 64'h40, 0, 0, 64'h0);
        cyc(0, 1, 64'h44, 0, 0, 64'h0);
        cyc(1, 0, 64'h0, 0, 0, 64'h0);
        cyc(0, 1, 64'h20, 0, 0, 64'h0);
        cyc(0, 0, 64'h0, 0, 0, 64'h0);
        cyc(0, 0, 64'h0, 1, 0, 64'h0);
        cyc(0, 0, 64'h0, 1, 0, 64'h0);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
